// File: rtl/shift_register_right_receiver.sv
// Serial-in / parallel-out receiver for an LSB-first stream, with a held output word and valid/ack handshake.
// The next word keeps collecting while the previous one waits for ack (double-buffered).
module shift_register_right_receiver #(
  parameter int WORD_LENGTH = 8,
  localparam int CNT_WIDTH = $clog2(WORD_LENGTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic                   shift_i,
  input  logic                   serial_in_i,
  input  logic                   word_ack_i,
  output logic [WORD_LENGTH-1:0] data_out_o,
  output logic                   word_valid_o,
  output logic [CNT_WIDTH-1:0]   bit_count_o,
  output logic                   overrun_o
);

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_LENGTH-1:0] sr_q, sr_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   overrun_q, overrun_d;

  logic [WORD_LENGTH-1:0] newWord;
  logic                   lastBit;

  assign newWord = {serial_in_i, sr_q[WORD_LENGTH-1:1]};
  assign lastBit = (count_q == CNT_WIDTH'(WORD_LENGTH - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= COLLECT;
      sr_q      <= '0;
      data_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Clear drops the partial word and overrun but must not lose a pending word.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    data_d    = data_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (clear_i) begin
      sr_d      = '0;
      count_d   = '0;
      overrun_d = 1'b0;
      if (word_ack_i && state_q == PENDING) begin
        state_d = COLLECT;
      end
    end else if (shift_i && lastBit) begin
      sr_d    = newWord;
      count_d = '0;
      if (state_q == COLLECT || word_ack_i) begin
        data_d  = newWord;
        state_d = PENDING;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      if (shift_i) begin
        sr_d    = newWord;
        count_d = count_q + CNT_WIDTH'(1);
      end
      if (word_ack_i && state_q == PENDING) begin
        state_d = COLLECT;
      end
    end
  end

  assign data_out_o   = data_q;
  assign word_valid_o = (state_q == PENDING);
  assign bit_count_o  = count_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_shift_register_right_receiver.sv
// Self-checking bench for shift_register_right_receiver (WORD_LENGTH=4): directed steps, then random traffic
// checked against a bit-queue reference model.
module tb_shift_register_right_receiver;

  localparam int WL = 4;
  localparam int CW = $clog2(WL + 1);

  logic          clk = 1'b0;
  logic          resetIn = 1'b1;
  logic          clearIn = 1'b0;
  logic          shiftIn = 1'b0;
  logic          serialIn = 1'b0;
  logic          ackIn = 1'b0;
  logic [WL-1:0] dataOut;
  logic          validOut;
  logic [CW-1:0] countOut;
  logic          overrunOut;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: received bits kept in arrival order, word rebuilt arithmetically.
  int            bitsQ[$];
  logic [WL-1:0] expData = '0;
  logic          expValid = 1'b0;
  logic          expOverrun = 1'b0;

  shift_register_right_receiver #(.WORD_LENGTH(WL)) dut (
    .clk_i        (clk),
    .reset_i      (resetIn),
    .clear_i      (clearIn),
    .shift_i      (shiftIn),
    .serial_in_i  (serialIn),
    .word_ack_i   (ackIn),
    .data_out_o   (dataOut),
    .word_valid_o (validOut),
    .bit_count_o  (countOut),
    .overrun_o    (overrunOut)
  );

  always #5 clk = ~clk;

  task automatic modelStep(input logic r, input logic c, input logic s, input logic b, input logic a);
    logic          done;
    logic [WL-1:0] word;
    done = 1'b0;
    word = '0;
    if (r) begin
      bitsQ.delete();
      expData = '0;
      expValid = 1'b0;
      expOverrun = 1'b0;
    end else if (c) begin
      bitsQ.delete();
      expOverrun = 1'b0;
      if (a) expValid = 1'b0;
    end else begin
      if (s) begin
        bitsQ.push_back(int'(b));
        if (bitsQ.size() == WL) begin
          for (int i = 0; i < WL; i++) word = word + WL'(bitsQ[i] * (1 << i));
          bitsQ.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!expValid || a) begin
          expData = word;
          expValid = 1'b1;
        end else begin
          expOverrun = 1'b1;
        end
      end else if (a) begin
        expValid = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    vectors++;
    assert (dataOut === expData) else begin
      miscompares++;
      $error("[TB] FAIL %s data_out observed=%h expected=%h", tag, dataOut, expData);
    end
    vectors++;
    assert (validOut === expValid) else begin
      miscompares++;
      $error("[TB] FAIL %s word_valid observed=%b expected=%b", tag, validOut, expValid);
    end
    vectors++;
    assert (countOut === CW'(bitsQ.size())) else begin
      miscompares++;
      $error("[TB] FAIL %s bit_count observed=%0d expected=%0d", tag, countOut, bitsQ.size());
    end
    vectors++;
    assert (overrunOut === expOverrun) else begin
      miscompares++;
      $error("[TB] FAIL %s overrun observed=%b expected=%b", tag, overrunOut, expOverrun);
    end
  endtask

  task automatic checkConst(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one edge's inputs, advance the model on that edge, then check #1 after it.
  task automatic applyStimulus(input logic r, input logic c, input logic s, input logic b, input logic a,
                               input string tag);
    resetIn = r; clearIn = c; shiftIn = s; serialIn = b; ackIn = a;
    @(posedge clk);
    modelStep(r, c, s, b, a);
    #1;
    checkOutput(tag);
  endtask

  task automatic sendWord(input logic [WL-1:0] w, input int gap, input logic ackLast, input string tag);
    for (int i = 0; i < WL; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, w[i], (i == WL - 1) ? ackLast : 1'b0, tag);
      if (i < WL - 1) begin
        for (int g = 0; g < gap; g++) begin
          applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, {tag, "_gap"});
          checkConst({tag, "_gapCount"}, 32'(countOut), 32'(i + 1));
          checkConst({tag, "_gapValid"}, 32'(validOut), 32'(0));
        end
      end
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "reset1");
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "reset2");
    checkConst("resetAll", {dataOut, validOut, countOut, overrunOut}, 32'(0));

    sendWord(4'hA, 0, 1'b0, "basic");
    checkConst("basicData", 32'(dataOut), 32'hA);
    checkConst("basicValid", 32'(validOut), 32'(1));
    checkConst("basicCount", 32'(countOut), 32'(0));

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ackA");
    checkConst("ackAValid", 32'(validOut), 32'(0));
    sendWord(4'hA, 3, 1'b0, "gaps");
    checkConst("gapsData", 32'(dataOut), 32'hA);
    checkConst("gapsValid", 32'(validOut), 32'(1));

    sendWord(4'h3, 0, 1'b1, "ackOnLast");
    checkConst("ackOnLastData", 32'(dataOut), 32'h3);
    checkConst("ackOnLastValid", 32'(validOut), 32'(1));
    checkConst("ackOnLastOvr", 32'(overrunOut), 32'(0));

    sendWord(4'hF, 0, 1'b0, "overrun");
    checkConst("overrunData", 32'(dataOut), 32'h3);
    checkConst("overrunFlag", 32'(overrunOut), 32'(1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ackAfterOvr");
    checkConst("ackAfterOvrValid", 32'(validOut), 32'(0));
    checkConst("ackAfterOvrFlag", 32'(overrunOut), 32'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "clearOvr");
    checkConst("clearOvrFlag", 32'(overrunOut), 32'(0));

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "partial1");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "partial2");
    checkConst("partialCount", 32'(countOut), 32'(2));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "clearMid");
    checkConst("clearMidCount", 32'(countOut), 32'(0));
    sendWord(4'h1, 0, 1'b0, "afterClear");
    checkConst("afterClearData", 32'(dataOut), 32'h1);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "preReset1");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "preReset2");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "midReset");
    checkConst("midResetAll", {dataOut, validOut, countOut, overrunOut}, 32'(0));

    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 24) == 0),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 4) == 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
